// File: rtl/branch_cond_unit.sv
// Registered branch-condition resolver: compares rs1/rs2, selects a condition by funct3,
// returns it through a valid/ready output register and keeps saturating statistics.
module branch_cond_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned ENC_MODE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  rs1,
    input  logic [XLEN-1:0]  rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             illegal,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    typedef enum logic [2:0] {
        OP_BEQ,
        OP_BNE,
        OP_BLT,
        OP_BGE,
        OP_BLTU,
        OP_BGEU,
        OP_ILL
    } op_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    op_e  op;
    logic eq;
    logic lt;
    logic ltu;
    logic cond;
    logic accept;

    assign eq       = (rs1 == rs2);
    assign lt       = ($signed(rs1) < $signed(rs2));
    assign ltu      = (rs1 < rs2);
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op = OP_ILL;
        if (ENC_MODE == 0) begin
            case (funct3)
                3'd0:    op = OP_BEQ;
                3'd1:    op = OP_BNE;
                3'd2:    op = OP_BLT;
                3'd3:    op = OP_BGE;
                3'd4:    op = OP_BLTU;
                3'd5:    op = OP_BGEU;
                default: op = OP_ILL;
            endcase
        end else begin
            case (funct3)
                3'b000:  op = OP_BEQ;
                3'b001:  op = OP_BNE;
                3'b100:  op = OP_BLT;
                3'b101:  op = OP_BGE;
                3'b110:  op = OP_BLTU;
                3'b111:  op = OP_BGEU;
                default: op = OP_ILL;
            endcase
        end
    end

    always_comb begin
        cond = 1'b0;
        case (op)
            OP_BEQ:  cond = eq;
            OP_BNE:  cond = !eq;
            OP_BLT:  cond = lt;
            OP_BGE:  cond = !lt;
            OP_BLTU: cond = ltu;
            OP_BGEU: cond = !ltu;
            default: cond = 1'b0;
        endcase
    end

    // taken/illegal only load on accept so they keep their value after a drain
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            taken     <= 1'b0;
            illegal   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            taken     <= cond;
            illegal   <= (op == OP_ILL);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (cnt_clr) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (accept && (op != OP_ILL)) begin
            if (branch_count != CNT_MAX) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (cond && (taken_count != CNT_MAX)) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Scoreboard bench for branch_cond_unit: RISC-V, dense and narrow-counter instances
// with a reference condition model and per-cycle counter model.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic        taken     [3];
    logic        illegal   [3];
    logic        cnt_clr   [3];
    logic [31:0] rs1       [3];
    logic [31:0] rs2       [3];
    logic [2:0]  f3        [3];
    logic [15:0] bc0, tc0, bc1, tc1;
    logic [2:0]  bc2, tc2;

    typedef struct {
        int         inst;
        logic [1:0] exp;
    } sb_t;

    sb_t sb[$];
    int  exp_bc [3] = '{0, 0, 0};
    int  exp_tc [3] = '{0, 0, 0};
    int  cnt_max [3] = '{65535, 65535, 7};
    int  enc [3] = '{1, 0, 1};
    int  n_checks = 0;
    int  n_err = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.XLEN(32), .CNT_W(16), .ENC_MODE(1)) u_rv (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .rs1(rs1[0]), .rs2(rs2[0]), .funct3(f3[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .taken(taken[0]), .illegal(illegal[0]),
        .cnt_clr(cnt_clr[0]), .branch_count(bc0), .taken_count(tc0)
    );

    branch_cond_unit #(.XLEN(32), .CNT_W(16), .ENC_MODE(0)) u_dense (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .rs1(rs1[1]), .rs2(rs2[1]), .funct3(f3[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .taken(taken[1]), .illegal(illegal[1]),
        .cnt_clr(cnt_clr[1]), .branch_count(bc1), .taken_count(tc1)
    );

    branch_cond_unit #(.XLEN(32), .CNT_W(3), .ENC_MODE(1)) u_sat (
        .clk(clk), .reset_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .rs1(rs1[2]), .rs2(rs2[2]), .funct3(f3[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .taken(taken[2]), .illegal(illegal[2]),
        .cnt_clr(cnt_clr[2]), .branch_count(bc2), .taken_count(tc2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // returns {illegal, taken}
    function automatic logic [1:0] ref_result(input int mode, input logic [2:0] f,
                                              input logic [31:0] a, input logic [31:0] b);
        int k;
        logic r;
        if (mode == 0) k = (f <= 3'd5) ? int'(f) : -1;
        else begin
            case (f)
                3'b000:  k = 0;
                3'b001:  k = 1;
                3'b100:  k = 2;
                3'b101:  k = 3;
                3'b110:  k = 4;
                3'b111:  k = 5;
                default: k = -1;
            endcase
        end
        case (k)
            0:       r = (a == b);
            1:       r = (a != b);
            2:       r = ($signed(a) < $signed(b));
            3:       r = ($signed(a) >= $signed(b));
            4:       r = (a < b);
            5:       r = (a >= b);
            default: r = 1'b0;
        endcase
        return {(k < 0), r};
    endfunction

    function automatic int dut_bc(input int i);
        case (i)
            0:       return int'(bc0);
            1:       return int'(bc1);
            default: return int'(bc2);
        endcase
    endfunction

    function automatic int dut_tc(input int i);
        case (i)
            0:       return int'(tc0);
            1:       return int'(tc1);
            default: return int'(tc2);
        endcase
    endfunction

    always @(negedge rst_n) begin
        sb.delete();
        for (int j = 0; j < 3; j++) begin
            exp_bc[j] = 0;
            exp_tc[j] = 0;
        end
    end

    // Monitor: check counters, retire delivered beats, then record new accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < 3; m++) begin
                logic [1:0] r;
                sb_t        e;
                check($sformatf("bcnt%0d", m), dut_bc(m), exp_bc[m]);
                check($sformatf("tcnt%0d", m), dut_tc(m), exp_tc[m]);
                if (out_valid[m] && out_ready[m]) begin
                    if (sb.size() == 0) begin
                        check($sformatf("sb_underflow%0d", m), 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("beat_inst%0d", m), m, e.inst);
                        check($sformatf("beat%0d", m), {illegal[m], taken[m]}, e.exp);
                    end
                end
                r = ref_result(enc[m], f3[m], rs1[m], rs2[m]);
                if (in_valid[m] && in_ready[m]) sb.push_back('{m, r});
                if (cnt_clr[m]) begin
                    exp_bc[m] = 0;
                    exp_tc[m] = 0;
                end else if (in_valid[m] && in_ready[m] && !r[1]) begin
                    if (exp_bc[m] < cnt_max[m]) exp_bc[m]++;
                    if (r[0] && exp_tc[m] < cnt_max[m]) exp_tc[m]++;
                end
            end
        end
    end

    task automatic send(input int i, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int cyc;
        cyc = 0;
        in_valid[i] = 1'b1;
        f3[i] = f;
        rs1[i] = a;
        rs2[i] = b;
        while (!in_ready[i] && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0; out_ready[i] = 1'b1; cnt_clr[i] = 1'b0;
            rs1[i] = '0; rs2[i] = '0; f3[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid[0], 0);
        check("rst_taken", taken[0], 0);
        check("rst_illegal", illegal[0], 0);
        check("rst_bc", bc0, 0);
        check("rst_tc", tc0, 0);
        check("rst_in_ready", in_ready[0], 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // RISC-V encodings, back to back
        send(0, 3'b000, 32'd5, 32'd5);
        check("lat1_valid", out_valid[0], 1);
        check("lat1_taken", taken[0], 1);
        send(0, 3'b001, 32'd5, 32'd5);
        send(0, 3'b100, 32'hFFFF_FFFF, 32'd1);
        send(0, 3'b101, 32'hFFFF_FFFF, 32'd1);
        send(0, 3'b110, 32'hFFFF_FFFF, 32'd1);
        send(0, 3'b111, 32'hFFFF_FFFF, 32'd1);
        check("rv_last_taken", taken[0], 1);
        @(posedge clk);
        #1;
        check("rv_drained", out_valid[0], 0);
        check("rv_hold_taken", taken[0], 1);
        check("rv_bc", bc0, 6);
        check("rv_tc", tc0, 3);
        send(0, 3'b010, 32'd4, 32'd4);
        check("rv_ill", illegal[0], 1);
        check("rv_ill_taken", taken[0], 0);
        check("rv_ill_bc", bc0, 6);

        // dense encodings
        send(1, 3'd0, 32'd5, 32'd5);
        send(1, 3'd1, 32'd5, 32'd6);
        send(1, 3'd2, 32'hFFFF_FFFF, 32'd1);
        send(1, 3'd3, 32'd1, 32'hFFFF_FFFF);
        send(1, 3'd4, 32'd1, 32'd2);
        send(1, 3'd5, 32'd2, 32'd1);
        check("dense_bc", bc1, 6);
        check("dense_tc", tc1, 6);
        send(1, 3'd6, 32'd5, 32'd5);
        check("dense_ill", illegal[1], 1);
        check("dense_ill_taken", taken[1], 0);
        @(posedge clk);
        #1;
        check("dense_ill_bc", bc1, 6);

        // backpressure
        send(0, 3'b000, 32'd3, 32'd3);
        out_ready[0] = 1'b0;
        in_valid[0] = 1'b1; f3[0] = 3'b001; rs1[0] = 32'd3; rs2[0] = 32'd3;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check("bp_in_ready", in_ready[0], 0);
            check("bp_valid", out_valid[0], 1);
            check("bp_taken", taken[0], 1);
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("bp_next_valid", out_valid[0], 1);
        check("bp_next_taken", taken[0], 0);

        // saturation at 3-bit counters
        for (int n = 0; n < 9; n++) send(2, 3'b000, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        check("sat_bc", bc2, 7);
        check("sat_tc", tc2, 7);

        // clear wins over a simultaneous accept
        cnt_clr[0] = 1'b1;
        send(0, 3'b000, 32'd7, 32'd7);
        cnt_clr[0] = 1'b0;
        check("clr_bc", bc0, 0);
        check("clr_tc", tc0, 0);
        check("clr_valid", out_valid[0], 1);
        check("clr_taken", taken[0], 1);

        // async reset during a held beat
        out_ready[0] = 1'b0;
        send(0, 3'b000, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        check("ar_held", out_valid[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", out_valid[0], 0);
        check("ar_taken", taken[0], 0);
        check("ar_bc", bc0, 0);
        check("ar_tc", tc0, 0);
        check("ar_sat_bc", bc2, 0);
        check("ar_in_ready", in_ready[0], 1);
        out_ready[0] = 1'b1;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
